seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_digit_lut.sv | 35 +++
 rtl/seg7_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller.
// No logic; pure declarations.
// No flow control.
package seg7_pkg;

  // All segments dark (active low), including DP.
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  // Lookup code that selects an unlit glyph (used by leading-zero blanking).
  localparam logic [4:0] CODE_BLANK = 5'h10;

  // Bit positions inside the 8-bit segment bus.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

endpackage

// File: rtl/seg7_digit_lut.sv
// Hex-to-segment decoder, active-low, DP bit held high (dark).
// Latency: purely combinational.
// Backpressure: none.
module seg7_digit_lut
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [7:0] pattern
);

  // Standard hex glyphs on bits 6..0; anything outside 0..F is blank.
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      5'h00: pattern = 8'hC0;
      5'h01: pattern = 8'hF9;
      5'h02: pattern = 8'hA4;
      5'h03: pattern = 8'hB0;
      5'h04: pattern = 8'h99;
      5'h05: pattern = 8'h92;
      5'h06: pattern = 8'h82;
      5'h07: pattern = 8'hF8;
      5'h08: pattern = 8'h80;
      5'h09: pattern = 8'h90;
      5'h0A: pattern = 8'h88;
      5'h0B: pattern = 8'h83;
      5'h0C: pattern = 8'hC6;
      5'h0D: pattern = 8'hA1;
      5'h0E: pattern = 8'h86;
      5'h0F: pattern = 8'h8E;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed common-anode 7-seg scanner with frame-aligned word updates.
// Latency: outputs registered; a new word shows from digit 0 of the frame after acceptance.
// Backpressure: load_ready drops while a word waits in the pending register.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 50000,
  parameter int IDX_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [PS_W-1:0]         presc;
  logic [IDX_W-1:0]        idx;
  logic                    tick;
  logic                    boundary;
  logic                    xfer;

  logic [4*NUM_DIGITS-1:0] act_val;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic                    act_blz;
  logic [4*NUM_DIGITS-1:0] pnd_val;
  logic [NUM_DIGITS-1:0]   pnd_dp;
  logic                    pnd_blz;
  logic                    pend;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_lz;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   an_drive;
  logic [4:0]              code;
  logic [7:0]              glyph;
  logic [7:0]              seg_drive;

  assign tick       = (presc == PS_LAST);
  assign boundary   = tick && (idx == IDX_LAST);
  assign load_ready = !pend;
  assign xfer       = load_valid && !pend;

  // Slot-length prescaler.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // Digit index steps once per slot and wraps at the frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           idx <= '0;
    else if (boundary) idx <= '0;
    else if (tick)     idx <= idx + 1'b1;
  end

  // Word staging: a waiting word commits at the boundary; a word arriving exactly
  // on an idle boundary skips staging so it still lands on a clean frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_val <= '0;
      act_dp  <= '0;
      act_blz <= 1'b0;
      pnd_val <= '0;
      pnd_dp  <= '0;
      pnd_blz <= 1'b0;
      pend    <= 1'b0;
    end else if (boundary && pend) begin
      act_val <= pnd_val;
      act_dp  <= pnd_dp;
      act_blz <= pnd_blz;
      pend    <= 1'b0;
    end else if (xfer && boundary) begin
      act_val <= value;
      act_dp  <= dp_mask;
      act_blz <= blank_lz;
    end else if (xfer) begin
      pnd_val <= value;
      pnd_dp  <= dp_mask;
      pnd_blz <= blank_lz;
      pend    <= 1'b1;
    end
  end

  // Select the current digit and decide whether it is a leading zero.
  always_comb begin
    cur_nib  = '0;
    cur_dp   = 1'b0;
    cur_lz   = 1'b0;
    an_drive = '1;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (act_val[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        cur_nib     = act_val[4*i +: 4];
        cur_dp      = act_dp[i];
        cur_lz      = zero_run && (i != 0);
        an_drive[i] = 1'b0;
      end
    end
  end

  assign code = (act_blz && cur_lz) ? CODE_BLANK : {1'b0, cur_nib};

  seg7_digit_lut u_lut (
    .code    (code),
    .pattern (glyph)
  );

  // DP follows the mask even on blanked digits.
  always_comb begin
    seg_drive         = glyph;
    seg_drive[SEG_DP] = ~cur_dp;
  end

  // Output register: one dark cycle after each tick, then drive the digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n      <= SEG_BLANK;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (tick) begin
        seg_n <= SEG_BLANK;
        an_n  <= '1;
      end else begin
        seg_n <= seg_drive;
        an_n  <= an_drive;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with 4 digits and 4-cycle slots.
// Expected digit slots are queued when a word is driven and compared per slot.
// Display is checked frame-aligned after frame_done.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic [7:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic armed = 1'b0;
  int dead_run = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .value(value), .dp_mask(dp_mask), .blank_lz(blank_lz),
    .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [15:0] v, input logic [3:0] dp,
                                         input logic blz, input int d);
    logic blank;
    blank = blz && (d > 0);
    for (int k = d; k < 4; k++) if (v[4*k +: 4] != 4'h0) blank = 1'b0;
    return {~dp[d], blank ? 7'h7F : glyph(v[4*d +: 4])};
  endfunction

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic push_word(input logic [15:0] v, input logic [3:0] dp, input logic blz);
    for (int d = 0; d < 4; d++) exp_q.push_back({an_of(d), exp_seg(v, dp, blz, d)});
  endtask

  // Slot monitor: compares each drive phase start against the queue head.
  always @(negedge clk) begin
    if (rst) dead_run = 0;
    else if (an_n == 4'hF) dead_run++;
    else begin
      if (dead_run > 0 && armed && exp_q.size() > 0) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        checks++;
        if (an_n !== e[11:8] || seg_n !== e[7:0]) begin
          errors++;
          $display("FAIL slot: got an_n=%h seg_n=%h, expected an_n=%h seg_n=%h",
                   an_n, seg_n, e[11:8], e[7:0]);
        end
        checks++;
        if (dead_run != 1) begin
          errors++;
          $display("FAIL dead_time: got %0d dark cycles, expected 1", dead_run);
        end
      end
      dead_run = 0;
    end
  end

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame: frame_done=%b after %0d cycles, expected 1", frame_done, n);
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    armed = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d slots left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic load_word(input logic [15:0] v, input logic [3:0] dp, input logic blz);
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_idle: got %b, expected 1", load_ready);
    end
    value = v; dp_mask = dp; blank_lz = blz; load_valid = 1'b1;
    push_word(v, dp, blz);
    @(negedge clk);
    load_valid = 1'b0;
    // Input changes without a handshake must not reach the display.
    value = 16'($urandom); dp_mask = 4'($urandom); blank_lz = 1'b0;
  endtask

  task automatic run_scoreboard();
    wait_frame();
    armed = 1'b1;
    wait_empty();
  endtask

  task automatic test_reset();
    logic [3:0] exp_an [5];
    exp_an = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hD};
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (seg_n !== 8'hFF || an_n !== 4'hF || load_ready !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: seg_n=%h an_n=%h rdy=%b fd=%b, expected FF F 1 0",
               seg_n, an_n, load_ready, frame_done);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (an_n !== exp_an[c]) begin
        errors++;
        $display("FAIL post_reset_scan[%0d]: an_n=%h, expected %h", c, an_n, exp_an[c]);
      end
      if (c == 0) begin
        checks++;
        if (seg_n !== 8'hC0) begin
          errors++;
          $display("FAIL post_reset_digit0: seg_n=%h, expected C0", seg_n);
        end
      end
    end
  endtask

  task automatic test_hex_glyphs();
    load_word(16'h12AF, 4'b0000, 1'b0);
    run_scoreboard();
  endtask

  task automatic test_blank_lz();
    load_word(16'h0000, 4'b0100, 1'b1);
    run_scoreboard();
  endtask

  task automatic test_pend_hold();
    int n;
    wait_frame();
    repeat (5) @(negedge clk);
    value = 16'h3456; dp_mask = 4'b0000; blank_lz = 1'b0; load_valid = 1'b1;
    push_word(16'h3456, 4'b0000, 1'b0);
    @(negedge clk);
    value = 16'h0789; dp_mask = 4'b1000; blank_lz = 1'b1;
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      checks++;
      if (load_ready !== 1'b0) begin
        errors++;
        $display("FAIL pend_ready: load_ready=%b, expected 0", load_ready);
      end
      if (an_n != 4'hF) begin
        for (int d = 0; d < 4; d++) if (an_n == an_of(d)) begin
          checks++;
          if (seg_n !== exp_seg(16'h0000, 4'b0100, 1'b1, d)) begin
            errors++;
            $display("FAIL old_frame digit %0d: seg_n=%h, expected %h", d, seg_n,
                     exp_seg(16'h0000, 4'b0100, 1'b1, d));
          end
        end
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL pend_release: frame_done=%b load_ready=%b, expected 1 1", frame_done, load_ready);
    end
    armed = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    push_word(16'h0789, 4'b1000, 1'b1);
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL second_accept: load_ready=%b, expected 0", load_ready);
    end
    wait_empty();
  endtask

  task automatic test_boundary_load();
    wait_frame();
    repeat (15) @(negedge clk);
    checks++;
    if (an_n !== 4'h7) begin
      errors++;
      $display("FAIL boundary_slot: an_n=%h, expected 7", an_n);
    end
    value = 16'hBCDE; dp_mask = 4'b0001; blank_lz = 1'b0; load_valid = 1'b1;
    push_word(16'hBCDE, 4'b0001, 1'b0);
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (frame_done !== 1'b1 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL boundary_direct: frame_done=%b load_ready=%b, expected 1 1", frame_done, load_ready);
    end
    armed = 1'b1;
    wait_empty();
  endtask

  task automatic test_reset_mid_slot();
    wait_frame();
    @(negedge clk);
    value = 16'h5555; dp_mask = 4'b1111; blank_lz = 1'b0; load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0 || an_n !== 4'hE) begin
      errors++;
      $display("FAIL pre_reset: load_ready=%b an_n=%h, expected 0 E", load_ready, an_n);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (an_n !== 4'hF || seg_n !== 8'hFF || frame_done !== 1'b0 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: an_n=%h seg_n=%h fd=%b rdy=%b, expected F FF 0 1",
               an_n, seg_n, frame_done, load_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_word(16'h0000, 4'b0000, 1'b0);
    run_scoreboard();
  endtask

  initial begin
    test_reset();
    test_hex_glyphs();
    test_blank_lz();
    test_pend_hold();
    test_boundary_load();
    test_reset_mid_slot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
